// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I R-type encoding constants and types.
// Used by the program writer (producer) and by the core's instruction
// decoder (consumer), so both ends of the instruction path agree on the
// opcode, funct3 and funct7 values.
package rv_pkg;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;  // ADD and SUB
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;  // SRL and SRA
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;   // SUB / SRA

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FULL   = 3'd3,
        ST_ERROR  = 3'd4
    } wr_state_t;

    // Assemble an R-type word from its fields.
    function automatic logic [31:0] rtype_word(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] funct3,
        input logic [4:0] rd
    );
        return {funct7, rs2, rs1, funct3, rd, OPCODE_RTYPE};
    endfunction

endpackage

// File: rtl/rtype_encoder.sv
// rtype_encoder: combinational ALU-op to RV32I R-type word encoder.
// Ports:
//   alu_op  in  4   ALU operation code
//   rd/rs1/rs2 in 5 register indices (rd = 0 encoded normally)
//   word    out 32  encoded instruction
//   illegal out 1   operation code has no R-type encoding (1010..1111)
module rtype_encoder
    import rv_pkg::*;
(
    input  logic [3:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic        illegal
);

    alu_op_t    op;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign op = alu_op_t'(alu_op);

    // Map operation code to funct3/funct7; unmapped codes flag illegal.
    always_comb begin
        funct3  = FUNCT3_ADD;
        funct7  = FUNCT7_BASE;
        illegal = 1'b0;
        case (op)
            ALU_ADD:  funct3 = FUNCT3_ADD;
            ALU_SUB:  begin funct3 = FUNCT3_ADD; funct7 = FUNCT7_ALT; end
            ALU_AND:  funct3 = FUNCT3_AND;
            ALU_OR:   funct3 = FUNCT3_OR;
            ALU_XOR:  funct3 = FUNCT3_XOR;
            ALU_SLL:  funct3 = FUNCT3_SLL;
            ALU_SRL:  funct3 = FUNCT3_SR;
            ALU_SRA:  begin funct3 = FUNCT3_SR; funct7 = FUNCT7_ALT; end
            ALU_SLT:  funct3 = FUNCT3_SLT;
            ALU_SLTU: funct3 = FUNCT3_SLTU;
            default:  illegal = 1'b1;
        endcase
        word = rtype_word(funct7, rs2, rs1, funct3, rd);
    end

endmodule

// File: rtl/rtype_program_writer.sv
// rtype_program_writer: accepts ALU micro-ops over valid/ready, encodes each
// as an R-type word and writes consecutive words to instruction memory
// through a stalling write port.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               pulse: clear pointer/count/err and open a session
//   in_valid/in_ready   request handshake; in_alu_op, in_rd/rs1/rs2 payload
//   mem_we/mem_ready    write request, accepted when both high
//   mem_addr/mem_wdata  byte address (BASE_ADDR + 4*count) and word
//   count, full, err    words written, count == DEPTH, sticky illegal op
module rtype_program_writer
    import rv_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_alu_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    // DEPTH = 2**ADDR_W expressed in the count width.
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    wr_state_t       state;
    logic [31:0]     enc_word;
    logic            enc_illegal;
    logic            handshake;
    logic [ADDR_W:0] count_next;
    logic [31:0]     addr_next;

    rtype_encoder u_encoder (
        .alu_op  (in_alu_op),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // start masks in_ready so nothing is consumed in a start cycle.
    assign in_ready   = (state == ST_ACCEPT) && !start;
    assign handshake  = in_valid && in_ready;
    assign count_next = count + {{ADDR_W{1'b0}}, 1'b1};
    assign addr_next  = BASE_ADDR + 32'({count_next, 2'b00});

    // Session FSM with the word register and count/address counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0000_0000;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            // Any pending write is abandoned.
            state    <= ST_ACCEPT;
            mem_we   <= 1'b0;
            mem_addr <= BASE_ADDR;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_ACCEPT: begin
                    if (handshake) begin
                        if (enc_illegal) begin
                            state <= ST_ERROR;
                            err   <= 1'b1;
                        end else begin
                            state     <= ST_WRITE;
                            mem_wdata <= enc_word;
                            mem_we    <= 1'b1;
                        end
                    end else begin
                        state <= ST_ACCEPT;
                    end
                end
                ST_WRITE: begin
                    // Address and data stay put until the memory takes them.
                    if (mem_ready) begin
                        mem_we   <= 1'b0;
                        count    <= count_next;
                        mem_addr <= addr_next;
                        if (count_next == DEPTH_CNT) begin
                            full  <= 1'b1;
                            state <= ST_FULL;
                        end else begin
                            state <= ST_ACCEPT;
                        end
                    end else begin
                        state <= ST_WRITE;
                    end
                end
                ST_FULL: begin
                    state <= ST_FULL;
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_program_writer.sv
// tb_rtype_program_writer: scoreboard bench for rtype_program_writer.
// Two instances: dut_b (ADDR_W=8) for the main flow, dut_s (ADDR_W=2) for
// the full condition. Expected writes are pushed when stimulus is driven;
// the memory monitor collects accepted writes for comparison.
module tb_rtype_program_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_drv = 1'b0;
    logic       valid_drv = 1'b0;
    logic       sel_small = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_op = 4'd0;
    logic [4:0] rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;

    logic        start_b, in_valid_b, in_ready_b, mem_we_b, full_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [8:0]  count_b;
    logic        start_s, in_valid_s, in_ready_s, mem_we_s, full_s, err_s;
    logic [31:0] addr_s, wdata_s;
    logic [2:0]  count_s;

    assign start_b    = start_drv & ~sel_small;
    assign in_valid_b = valid_drv & ~sel_small;
    assign start_s    = start_drv & sel_small;
    assign in_valid_s = valid_drv & sel_small;

    rtype_program_writer #(.ADDR_W(8), .BASE_ADDR(32'h0000_0000)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_alu_op(alu_op), .in_rd(rd), .in_rs1(rs1),
        .in_rs2(rs2), .mem_we(mem_we_b), .mem_ready(mem_ready),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .count(count_b),
        .full(full_b), .err(err_b)
    );

    rtype_program_writer #(.ADDR_W(2), .BASE_ADDR(32'h0000_0000)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .in_alu_op(alu_op), .in_rd(rd), .in_rs1(rs1),
        .in_rs2(rs2), .mem_we(mem_we_s), .mem_ready(mem_ready),
        .mem_addr(addr_s), .mem_wdata(wdata_s), .count(count_s),
        .full(full_s), .err(err_s)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] exp_b[$];
    logic [63:0] obs_b[$];
    logic [63:0] exp_s[$];
    logic [63:0] obs_s[$];

    // Memory-side monitor: record every accepted write as {addr, data}.
    always @(posedge clk) begin
        if (!reset && mem_we_b && mem_ready) obs_b.push_back({addr_b, wdata_b});
        if (!reset && mem_we_s && mem_ready) obs_s.push_back({addr_s, wdata_s});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference encoding from the RV32I R-type table.
    function automatic logic [31:0] model_word(input logic [3:0] op,
        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        logic [2:0] f3;
        logic [6:0] f7;
        f7 = 7'h00;
        case (op)
            4'd0: f3 = 3'b000;
            4'd1: begin f3 = 3'b000; f7 = 7'h20; end
            4'd2: f3 = 3'b111;
            4'd3: f3 = 3'b110;
            4'd4: f3 = 3'b100;
            4'd5: f3 = 3'b001;
            4'd6: f3 = 3'b101;
            4'd7: begin f3 = 3'b101; f7 = 7'h20; end
            4'd8: f3 = 3'b010;
            4'd9: f3 = 3'b011;
            default: f3 = 3'b000;
        endcase
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    // Decoder-side view: word back to ALU op code; 5'h1F if not decodable.
    function automatic logic [4:0] model_decode(input logic [31:0] w);
        logic [9:0] key;
        key = {w[31:25], w[14:12]};
        if (w[6:0] != 7'b0110011) return 5'h1F;
        case (key)
            {7'h00, 3'b000}: return 5'd0;
            {7'h20, 3'b000}: return 5'd1;
            {7'h00, 3'b111}: return 5'd2;
            {7'h00, 3'b110}: return 5'd3;
            {7'h00, 3'b100}: return 5'd4;
            {7'h00, 3'b001}: return 5'd5;
            {7'h00, 3'b101}: return 5'd6;
            {7'h20, 3'b101}: return 5'd7;
            {7'h00, 3'b010}: return 5'd8;
            {7'h00, 3'b011}: return 5'd9;
            default:         return 5'h1F;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_drv = 1'b1;
        step();
        start_drv = 1'b0;
    endtask

    // Present one request and hold it until the selected DUT accepts it.
    task automatic send(input logic [3:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2);
        bit ok;
        alu_op = op; rd = d; rs1 = s1; rs2 = s2;
        valid_drv = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (sel_small ? in_ready_s : in_ready_b) ok = 1'b1;
            step();
        end
        valid_drv = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL handshake_timeout: op=%0d not accepted, in_ready stayed 0, required 1", op);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready_b, mem_we_b, addr_b, wdata_b, count_b, full_b, err_b} !==
            {1'b0, 1'b0, 32'h0, 32'h0, 9'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b we=%b addr=%h data=%h cnt=%0d full=%b err=%b, required all zero",
                     in_ready_b, mem_we_b, addr_b, wdata_b, count_b, full_b, err_b);
        end
        n_cmp++;
        if ({in_ready_s, mem_we_s, count_s} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_small: rdy=%b we=%b cnt=%0d, required 0", in_ready_s, mem_we_s, count_s);
        end
        step();
    endtask

    task automatic test_single_write();
        logic [63:0] e, o;
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if ({in_ready_b, addr_b} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL start_ready: rdy=%b addr=%h, required 1 / 00000000", in_ready_b, addr_b);
        end
        step();
        mem_ready = 1'b1;
        exp_b.push_back({32'h0000_0000, 32'h0031_00B3});
        send(4'd0, 5'd1, 5'd2, 5'd3);
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, in_ready_b, wdata_b} !== {1'b1, 1'b0, 32'h0031_00B3}) begin
            n_fail++;
            $display("FAIL add_write_cycle: we=%b rdy=%b data=%h, required 1 0 003100b3", mem_we_b, in_ready_b, wdata_b);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({in_ready_b, mem_we_b, count_b, addr_b} !== {1'b1, 1'b0, 9'd1, 32'h4}) begin
            n_fail++;
            $display("FAIL add_after_write: rdy=%b we=%b cnt=%0d addr=%h, required 1 0 1 00000004",
                     in_ready_b, mem_we_b, count_b, addr_b);
        end
        step();
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_cmp++;
            if (obs_b.size() == 0) begin
                n_fail++;
                $display("FAIL single_sb: no write seen, required %h", e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL single_sb: got %h, required %h", o, e);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] e, o;
        mem_ready = 1'b0;
        exp_b.push_back({32'h0000_0004, 32'h4073_02B3});
        send(4'd1, 5'd5, 5'd6, 5'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_we_b, wdata_b, addr_b, count_b} !== {1'b1, 32'h4073_02B3, 32'h4, 9'd1}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: we=%b data=%h addr=%h cnt=%0d, required 1 407302b3 4 1",
                         i, mem_we_b, wdata_b, addr_b, count_b);
            end
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mem_we_b !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_fourth: we=%b, required 1", mem_we_b);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, count_b} !== {1'b0, 9'd2}) begin
            n_fail++;
            $display("FAIL stall_done: we=%b cnt=%0d, required 0 2", mem_we_b, count_b);
        end
        step();
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_cmp++;
            if (obs_b.size() == 0) begin
                n_fail++;
                $display("FAIL stall_sb: no write seen, required %h", e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL stall_sb: got %h, required %h", o, e);
                end
            end
        end
        n_cmp++;
        if (obs_b.size() != 0) begin
            n_fail++;
            $display("FAIL stall_extra: %0d extra writes, required 0", obs_b.size());
            obs_b.delete();
        end
    endtask

    task automatic test_all_ops();
        logic [63:0] e, o;
        pulse_start();
        mem_ready = 1'b1;
        for (int op = 0; op < 10; op++) begin
            exp_b.push_back({32'(op * 4), model_word(4'(op), 5'd3, 5'd1, 5'd2)});
            send(4'(op), 5'd3, 5'd1, 5'd2);
        end
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if (count_b !== 9'd10) begin
            n_fail++;
            $display("FAIL all_ops_count: cnt=%0d, required 10", count_b);
        end
        step();
        for (int op = 0; op < 10; op++) begin
            e = exp_b.pop_front();
            n_cmp++;
            if (obs_b.size() == 0) begin
                n_fail++;
                $display("FAIL all_ops_sb[%0d]: no write seen, required %h", op, e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL all_ops_sb[%0d]: got %h, required %h", op, o, e);
                end
                n_cmp++;
                if (model_decode(o[31:0]) !== 5'(op)) begin
                    n_fail++;
                    $display("FAIL all_ops_decode[%0d]: decoded %0d, required %0d", op, model_decode(o[31:0]), op);
                end
            end
        end
    endtask

    task automatic test_illegal();
        send(4'b1010, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, err_b, in_ready_b} !== 3'b010) begin
            n_fail++;
            $display("FAIL illegal_state: we=%b err=%b rdy=%b, required 0 1 0", mem_we_b, err_b, in_ready_b);
        end
        step();
        step();
        n_cmp++;
        if (obs_b.size() != 0 || count_b !== 9'd10) begin
            n_fail++;
            $display("FAIL illegal_nowrite: writes=%0d cnt=%0d, required 0 10", obs_b.size(), count_b);
            obs_b.delete();
        end
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if ({err_b, count_b, in_ready_b, addr_b} !== {1'b0, 9'd0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL illegal_restart: err=%b cnt=%0d rdy=%b addr=%h, required 0 0 1 0",
                     err_b, count_b, in_ready_b, addr_b);
        end
        step();
    endtask

    task automatic test_full();
        logic [63:0] e, o;
        sel_small = 1'b1;
        pulse_start();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_s.push_back({32'(i * 4), model_word(4'(i), 5'd4, 5'd5, 5'd6)});
            send(4'(i), 5'd4, 5'd5, 5'd6);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({full_s, count_s, in_ready_s, addr_s} !== {1'b1, 3'd4, 1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL full_state: full=%b cnt=%0d rdy=%b addr=%h, required 1 4 0 10",
                     full_s, count_s, in_ready_s, addr_s);
        end
        step();
        valid_drv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready_s, mem_we_s} !== 2'b00) begin
                n_fail++;
                $display("FAIL full_block[%0d]: rdy=%b we=%b, required 0 0", i, in_ready_s, mem_we_s);
            end
            step();
        end
        valid_drv = 1'b0;
        while (exp_s.size() > 0) begin
            e = exp_s.pop_front();
            n_cmp++;
            if (obs_s.size() == 0) begin
                n_fail++;
                $display("FAIL full_sb: no write seen, required %h", e);
            end else begin
                o = obs_s.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL full_sb: got %h, required %h", o, e);
                end
            end
        end
        n_cmp++;
        if (obs_s.size() != 0) begin
            n_fail++;
            $display("FAIL full_extra: %0d extra writes, required 0", obs_s.size());
            obs_s.delete();
        end
        pulse_start();
        @(negedge clk);
        n_cmp++;
        if ({addr_s, count_s, full_s, in_ready_s} !== {32'h0, 3'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL full_restart: addr=%h cnt=%0d full=%b rdy=%b, required 0 0 0 1",
                     addr_s, count_s, full_s, in_ready_s);
        end
        step();
        sel_small = 1'b0;
    endtask

    task automatic test_start_mid_write();
        logic [63:0] e, o;
        pulse_start();
        mem_ready = 1'b1;
        exp_b.push_back({32'h0, model_word(4'd0, 5'd1, 5'd2, 5'd3)});
        send(4'd0, 5'd1, 5'd2, 5'd3);
        step();
        mem_ready = 1'b0;
        send(4'd1, 5'd5, 5'd6, 5'd7);
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, count_b} !== {1'b1, 9'd1}) begin
            n_fail++;
            $display("FAIL smw_stalled: we=%b cnt=%0d, required 1 1", mem_we_b, count_b);
        end
        step();
        start_drv = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready_b !== 1'b0) begin
            n_fail++;
            $display("FAIL smw_mask: rdy=%b during start, required 0", in_ready_b);
        end
        step();
        start_drv = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, count_b, in_ready_b, addr_b} !== {1'b0, 9'd0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL smw_after: we=%b cnt=%0d rdy=%b addr=%h, required 0 0 1 0",
                     mem_we_b, count_b, in_ready_b, addr_b);
        end
        mem_ready = 1'b1;
        step();
        step();
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_cmp++;
            if (obs_b.size() == 0) begin
                n_fail++;
                $display("FAIL smw_sb: no write seen, required %h", e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL smw_sb: got %h, required %h", o, e);
                end
            end
        end
        n_cmp++;
        if (obs_b.size() != 0) begin
            n_fail++;
            $display("FAIL smw_spurious: %0d abandoned writes completed, required 0", obs_b.size());
            obs_b.delete();
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] e, o;
        mem_ready = 1'b1;
        exp_b.push_back({32'h0, model_word(4'd2, 5'd8, 5'd9, 5'd10)});
        send(4'd2, 5'd8, 5'd9, 5'd10);
        step();
        mem_ready = 1'b0;
        send(4'd3, 5'd11, 5'd12, 5'd13);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({mem_we_b, count_b, in_ready_b, addr_b, err_b} !== {1'b0, 9'd0, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmw_async: we=%b cnt=%0d rdy=%b addr=%h err=%b, required 0 0 0 0 0",
                     mem_we_b, count_b, in_ready_b, addr_b, err_b);
        end
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        step();
        @(negedge clk);
        n_cmp++;
        if ({mem_we_b, in_ready_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL rmw_idle: we=%b rdy=%b, required 0 0", mem_we_b, in_ready_b);
        end
        step();
        while (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            n_cmp++;
            if (obs_b.size() == 0) begin
                n_fail++;
                $display("FAIL rmw_sb: no write seen, required %h", e);
            end else begin
                o = obs_b.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rmw_sb: got %h, required %h", o, e);
                end
            end
        end
        n_cmp++;
        if (obs_b.size() != 0) begin
            n_fail++;
            $display("FAIL rmw_spurious: %0d writes after reset, required 0", obs_b.size());
            obs_b.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall();
        test_all_ops();
        test_illegal();
        test_full();
        test_start_mid_write();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
